// File: rtl/tdm_slot_engine_if.sv
// Host-side slot bus of the TDM framer.
// The host writes the tx table and receives rx bytes.
interface tdm_slot_engine_if #(
  parameter int SLOT_W = 5,
  parameter int BITS   = 8
);
  logic              tx_wr;
  logic [SLOT_W-1:0] tx_slot;
  logic [BITS-1:0]   tx_data;
  logic              rx_valid;
  logic [BITS-1:0]   rx_data;
  logic [SLOT_W-1:0] rx_slot;

  modport master (
    output tx_wr, tx_slot, tx_data,
    input  rx_valid, rx_data, rx_slot
  );

  modport slave (
    input  tx_wr, tx_slot, tx_data,
    output rx_valid, rx_data, rx_slot
  );
endinterface

// File: rtl/tdm_slot_engine.sv
// ST-BUS style TDM framer: oversampled c4/f0, per-slot rx/tx bytes,
// flywheel frame sync with error pulse, optional per-slot loopback.
module tdm_slot_engine #(
  parameter int              CHANNELS   = 32,
  parameter int              BITS       = 8,
  parameter int              C4_PER_BIT = 2,
  parameter logic [BITS-1:0] IDLE_BYTE  = 8'hFF
) (
  input  logic clk50,
  input  logic reset_n,
  input  logic c4,
  input  logic f0,
  input  logic dst_in,
  input  logic loopback,
  output logic dst_out,
  output logic locked,
  output logic frame_err,
  tdm_slot_engine_if.slave bus
);
  localparam int SLOT_W      = $clog2(CHANNELS);
  localparam int FRAME_EDGES = CHANNELS * BITS * C4_PER_BIT;
  localparam int E_W         = $clog2(FRAME_EDGES);
  localparam int P_W         = $clog2(C4_PER_BIT);
  localparam int K_W         = $clog2(BITS);
  localparam logic [E_W-1:0] E_LAST = E_W'(FRAME_EDGES - 1);
  localparam logic [P_W-1:0] P_LAST = P_W'(C4_PER_BIT - 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(BITS - 1);

  logic [2:0]        c4_s;
  logic [1:0]        f0_s;
  logic [1:0]        d_s;
  logic              c4_edge;
  logic              f0_low;
  logic [E_W-1:0]    e;
  logic [E_W-1:0]    e_nx;
  logic [E_W-1:0]    b;
  logic [P_W-1:0]    p;
  logic [K_W-1:0]    k;
  logic [SLOT_W-1:0] s;
  logic              lock_nx;
  logic              err_nx;
  logic [BITS-1:0]   rx_sh;
  logic [BITS-1:0]   rx_nx;
  logic [BITS-1:0]   tx_sh;
  logic              rx_valid;
  logic [BITS-1:0]   rx_data;
  logic [SLOT_W-1:0] rx_slot;
  logic [BITS-1:0]   tx_table [CHANNELS];

  assign c4_edge = c4_s[1] & ~c4_s[2];
  assign f0_low  = ~f0_s[1];

  assign bus.rx_valid = rx_valid;
  assign bus.rx_data  = rx_data;
  assign bus.rx_slot  = rx_slot;

  always_comb begin
    e_nx = e + 1'b1;
    if (f0_low || e == E_LAST) e_nx = '0;
    b       = E_W'(e_nx / E_W'(C4_PER_BIT));
    p       = P_W'(e_nx % E_W'(C4_PER_BIT));
    s       = SLOT_W'(b / E_W'(BITS));
    k       = K_W'(b % E_W'(BITS));
    lock_nx = locked | f0_low;
    err_nx  = locked & (f0_low ? (e != E_LAST) : (e == E_LAST));
    rx_nx   = (rx_sh << 1) | BITS'(d_s[1]);
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      c4_s      <= '0;
      f0_s      <= '0;
      d_s       <= '0;
      e         <= '0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
      dst_out   <= 1'b1;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      rx_slot   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      for (int i = 0; i < CHANNELS; i++) tx_table[i] <= IDLE_BYTE;
    end else begin
      c4_s      <= {c4_s[1:0], c4};
      f0_s      <= {f0_s[0], f0};
      d_s       <= {d_s[0], dst_in};
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (bus.tx_wr && int'(bus.tx_slot) < CHANNELS)
        tx_table[bus.tx_slot] <= bus.tx_data;
      // loopback write is last so it beats a same-slot host write
      if (loopback && rx_valid)
        tx_table[rx_slot] <= rx_data;
      if (c4_edge) begin
        e         <= e_nx;
        locked    <= lock_nx;
        frame_err <= err_nx;
        if (lock_nx && p == P_LAST) begin
          rx_sh <= rx_nx;
          if (k == K_LAST) begin
            rx_valid <= 1'b1;
            rx_data  <= rx_nx;
            rx_slot  <= s;
          end
        end
        if (lock_nx && p == '0) begin
          if (k == '0) begin
            tx_sh   <= tx_table[s];
            dst_out <= tx_table[s][BITS-1];
          end else begin
            tx_sh   <= tx_sh << 1;
            dst_out <= tx_sh[BITS-2];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tdm_slot_engine.sv
// Directed bench for tdm_slot_engine: lock, rx, tx table, write race,
// sync errors, flywheel, loopback priority and mid-frame reset.
module tb_tdm_slot_engine;
  localparam int CH = 32;
  localparam int FE = 512;

  logic clk50 = 1'b0;
  logic reset_n = 1'b0;
  logic c4 = 1'b0;
  logic f0 = 1'b1;
  logic dst_in = 1'b1;
  logic loopback = 1'b0;
  logic dst_out, locked, frame_err;

  tdm_slot_engine_if #(.SLOT_W(5), .BITS(8)) bus ();

  tdm_slot_engine dut (
    .clk50(clk50), .reset_n(reset_n), .c4(c4), .f0(f0),
    .dst_in(dst_in), .loopback(loopback), .dst_out(dst_out),
    .locked(locked), .frame_err(frame_err), .bus(bus)
  );

  always #10 clk50 = ~clk50;

  int nchk = 0;
  int nerr = 0;
  int errcnt = 0;
  int wr_e = -1;
  int wr_ofs = 0;
  logic [4:0] wr_slot = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] rxb [CH];
  logic [7:0] tx_exp [CH];
  logic txbits [FE];
  logic [12:0] rxq [$];

  always @(negedge clk50) begin
    if (frame_err) errcnt++;
    if (bus.rx_valid) rxq.push_back({bus.rx_slot, bus.rx_data});
  end

  task automatic chk(input string tag, input int got, input int want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic host_wr(input logic [4:0] sl, input logic [7:0] d);
    bus.tx_wr = 1'b1; bus.tx_slot = sl; bus.tx_data = d;
    @(negedge clk50);
    bus.tx_wr = 1'b0;
    @(negedge clk50);
  endtask

  // one c4 period: 4 clk high, 4 clk low; optional host write timed to the edge
  task automatic pulse(input int ei, input logic f0v, input logic dv,
                       output logic dout);
    f0 = f0v; dst_in = dv; c4 = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (n == 4) c4 = 1'b0;
      if (wr_e == ei && n == 2 + wr_ofs) begin
        bus.tx_wr = 1'b1; bus.tx_slot = wr_slot; bus.tx_data = wr_data;
      end else begin
        bus.tx_wr = 1'b0;
      end
      @(negedge clk50);
    end
    dout = dst_out;
  endtask

  task automatic run_frame(input bit sync, input int n_edges);
    int s, k;
    logic [7:0] by;
    logic dout;
    rxq.delete();
    for (int e = 0; e < n_edges; e++) begin
      s = e / 16; k = (e / 2) % 8; by = rxb[s];
      pulse(e, !(sync && e == 0), by[7-k], dout);
      txbits[e] = dout;
    end
    f0 = 1'b1;
  endtask

  task automatic check_rx(input string tag);
    logic [12:0] it;
    chk({tag, "_cnt"}, rxq.size(), CH);
    for (int i = 0; i < CH && i < rxq.size(); i++) begin
      it = rxq[i];
      chk($sformatf("%s_slot%0d", tag, i), int'(it[12:8]), i);
      chk($sformatf("%s_data%0d", tag, i), int'(it[7:0]), int'(rxb[i]));
    end
  endtask

  task automatic check_tx(input string tag);
    logic [7:0] got;
    int hold;
    hold = 0;
    for (int s = 0; s < CH; s++) begin
      got = '0;
      for (int k = 0; k < 8; k++) begin
        got = {got[6:0], txbits[s*16 + k*2]};
        if (txbits[s*16 + k*2 + 1] !== txbits[s*16 + k*2]) hold++;
      end
      chk($sformatf("%s_s%0d", tag, s), int'(got), int'(tx_exp[s]));
    end
    chk({tag, "_hold"}, hold, 0);
  endtask

  initial begin
    int ones;
    bus.tx_wr = 1'b0; bus.tx_slot = '0; bus.tx_data = '0;
    for (int i = 0; i < CH; i++) begin
      rxb[i] = 8'(i);
      tx_exp[i] = 8'hFF;
    end
    repeat (3) @(negedge clk50);
    chk("rst_dout", dst_out, 1);
    chk("rst_locked", locked, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_rxv", bus.rx_valid, 0);
    chk("rst_rxd", bus.rx_data, 0);
    chk("rst_rxs", bus.rx_slot, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk50);

    host_wr(5'd5, 8'hA5);
    tx_exp[5] = 8'hA5;
    run_frame(1, FE);
    chk("f1_locked", locked, 1);
    check_rx("f1_rx");
    check_tx("f1_tx");
    chk("f1_err", errcnt, 0);

    wr_e = 48; wr_ofs = 0; wr_slot = 5'd3; wr_data = 8'h3C;
    run_frame(1, FE);
    wr_e = -1;
    check_tx("race_old");
    run_frame(1, FE);
    tx_exp[3] = 8'h3C;
    check_tx("race_new");
    chk("race_err", errcnt, 0);

    run_frame(1, 300);
    chk("early_none", errcnt, 0);
    run_frame(1, FE);
    chk("early_err", errcnt, 1);
    check_tx("early_tx");
    check_rx("early_rx");

    run_frame(0, FE);
    chk("fly_err", errcnt, 2);
    chk("fly_locked", locked, 1);
    check_tx("fly_tx");
    check_rx("fly_rx");

    loopback = 1'b1;
    rxb[7] = 8'h5A;
    wr_e = 127; wr_ofs = 1; wr_slot = 5'd7; wr_data = 8'h11;
    run_frame(1, FE);
    wr_e = -1;
    loopback = 1'b0;
    check_rx("lb_rx");
    for (int i = 0; i < CH; i++) tx_exp[i] = rxb[i];
    run_frame(1, FE);
    check_tx("lb_tx");

    host_wr(5'd12, 8'h00);
    run_frame(1, 201);
    chk("pre_rst_dout", dst_out, 0);
    chk("pre_rst_locked", locked, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_dout", dst_out, 1);
    chk("mid_rst_locked", locked, 0);
    @(negedge clk50);
    reset_n = 1'b1;
    @(negedge clk50);
    run_frame(0, 20);
    ones = 0;
    for (int e = 0; e < 20; e++) if (txbits[e] === 1'b1) ones++;
    chk("unlk_locked", locked, 0);
    chk("unlk_rx", rxq.size(), 0);
    chk("unlk_dout", ones, 20);
    for (int i = 0; i < CH; i++) tx_exp[i] = 8'hFF;
    run_frame(1, FE);
    chk("relock", locked, 1);
    check_tx("relock_tx");
    check_rx("relock_rx");
    chk("relock_err", errcnt, 2);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/tdm_slot_engine.md
# tdm_slot_engine

Parametrised ST-BUS style TDM framer for the converter path. It receives the serial TDM stream on the c4/f0 frame clock and deserialises each timeslot into a byte with a slot index. It also serialises a per-slot transmit byte table back onto the outgoing stream. The whole block runs on clk50; c4, f0 and the serial input are oversampled and never used as clocks. It adds programmable slot count, frame-sync error detection with flywheel, and per-slot loopback.

## Interface
- CHANNELS, 32, timeslots per frame (≥2)
- BITS, 8, bits per timeslot, sent and received MSB first
- C4_PER_BIT, 2, c4 periods per bit (≥2)
- IDLE_BYTE, 8'hFF, reset value of every tx table entry
- Localparams: SLOT_W = clog2(CHANNELS); FRAME_EDGES = CHANNELS*BITS*C4_PER_BIT
- clk50 in 1: sole clock, all logic on its rising edge
- reset_n in 1: asynchronous assert, active-low
- c4 in 1: TDM edge clock, asynchronous to clk50, ≤ clk50/8
- f0 in 1: frame sync, active-low, asynchronous
- dst_in in 1: serial TDM receive data
- loopback in 1: quasi-static; 1 = received bytes overwrite tx table
- tx_wr in 1: host write strobe into tx table
- tx_slot in SLOT_W: host write address (≥CHANNELS ignored)
- tx_data in BITS: host write data
- dst_out out 1: serial TDM transmit data
- rx_valid out 1: one-cycle pulse, rx_data/rx_slot valid
- rx_data out BITS: received slot byte
- rx_slot out SLOT_W: slot index of rx_data
- locked out 1: frame alignment acquired
- frame_err out 1: one-cycle pulse on sync error

## Operation
- Input conditioning: c4, f0, dst_in each pass two sync flops; c4 edge detect = rising edge of synced c4 (third flop compare). All frame events occur on clk50 cycles where edge detect = 1 ("edge"). f0 and dst_in are taken from their synced copies in the same cycle.
- Edge counter e (0..FRAME_EDGES-1): on edge with f0 = 0, e := 0, locked := 1; frame_err pulses if locked was already 1 and previous e ≠ FRAME_EDGES-1. On edge with f0 = 1: if e = FRAME_EDGES-1, e := 0 (flywheel) and frame_err pulses if locked; else e := e+1.
- Decode: bit b = e / C4_PER_BIT, phase p = e % C4_PER_BIT, slot s = b / BITS, bit position k = b % BITS.
- Receive (locked only): at p = C4_PER_BIT-1, shift dst_in into rx shift register LSB. When k = BITS-1, the completed byte is presented: rx_data, rx_slot := s, rx_valid = 1 for exactly one cycle, on the cycle after that edge.
- Transmit: at p = 0 with k = 0, load tx shift register from tx_table[s]; dst_out := MSB. At p = 0 with k > 0, shift; dst_out := bit BITS-1-k of the loaded byte. Byte is snapshotted at slot start; later writes affect the next frame.
- Host write: tx_wr with tx_slot < CHANNELS writes tx_table[tx_slot] on that cycle. A write coinciding with the slot-start load of the same slot takes effect next frame; the old value is transmitted.
- Loopback = 1: each rx_valid also writes rx_data into tx_table[rx_slot]. When it coincides with tx_wr to the same slot, loopback wins.
- Unlocked: dst_out = 1, no rx_valid, e counts but is meaningless until the first f0 low.

## Timing
- Reset (async, reset_n = 0): dst_out 1, rx_valid 0, rx_data 0, rx_slot 0, locked 0, frame_err 0, e 0, sync flops 0, tx_table all IDLE_BYTE. Release is synchronous to clk50.
- c4 pin rise to edge cycle: 3 clk50 cycles (±1 for metastability).
- Edge cycle to dst_out update: 1 cycle.
- Last sampling edge of slot to rx_valid: 1 cycle.
- A byte received in slot s with loopback is retransmitted in slot s of the next frame.
- reset_n low mid-frame: immediate return to reset values; relock requires a new f0 low.

## Test plan
- Lock and RX, defaults: f0 low then 512 edges, dst_in = slot index byte per slot -> locked = 1; 32 rx_valid pulses with rx_slot 0..31 and rx_data 0x00..0x1F; no frame_err.
- TX table: write tx_table[5] = 0xA5 before the frame -> dst_out carries 1,0,1,0,0,1,0,1 over bits 40..47, each held 2 c4 periods; all other slots 0xFF.
- Write race: tx_wr slot 3 = 0x3C on the slot-3 load cycle -> current frame sends the old 0xFF, next frame sends 0x3C.
- Sync errors: f0 low at e = 300 -> frame_err pulse, e restarts at 0. Then omit f0 for one frame -> flywheel at e = 511 with frame_err pulse, slots stay aligned.
- Loopback: loopback = 1, receive 0x5A in slot 7, host writes 0x11 to slot 7 on the same cycle -> slot 7 transmits 0x5A next frame.
- Reset mid-frame: reset_n low at e = 200 -> dst_out = 1 and locked = 0 at once; tx_table reads IDLE_BYTE after relock.
